// File: rtl/clk_ratio_meter_pkg.sv
// clk_ratio_meter_pkg: shared FSM state type and counter saturation helper
package clk_ratio_meter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;
    function automatic logic [31:0] sat_val(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
    endfunction
endpackage

// File: rtl/clk_ratio_meter_sync_edge_det.sv
// sync_edge_det: 2-flop synchroniser plus delayed copy giving rise/fall pulses
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);
    logic r_s1, r_s2, r_d;
    // synchronise the asynchronous input and keep one delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_d  <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_d  <= r_s2;
        end
    end
    assign o_rise = r_s2 & ~r_d;
    assign o_fall = ~r_s2 & r_d;
endmodule

// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter: measures period/high time of clk_in in clk cycles; optional duty check via CLK_RATIO_METER_DUTY_CHECK_EN
module clk_ratio_meter
    import clk_ratio_meter_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             no_clk,
    output logic             duty_err
);
    localparam int               MW      = $clog2(LOCK_CNT);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(sat_val(CNT_W));
    localparam logic [CNT_W-1:0] TO      = CNT_W'(TIMEOUT);
    localparam logic [MW-1:0]    M_TOP   = MW'(LOCK_CNT - 1);

    state_t           r_state, w_next;
    logic             w_rise, w_fall, w_start, w_publish, w_timeout;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_period;
    logic [MW-1:0]    w_mcnt;
    logic [CNT_W-1:0] r_hcnt, r_lcnt, r_period, r_high;
    logic [MW-1:0]    r_mcnt;
    logic             r_first, r_valid, r_locked, r_no_clk;

    sync_edge_det u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (clk_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next state: an edge always beats a timeout in the same cycle
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)      w_next = w_rise ? HIGH : IDLE;
        else if (r_state == HIGH) w_next = w_fall ? LOW : w_timeout ? IDLE : HIGH;
        else                      w_next = w_rise ? HIGH : w_timeout ? IDLE : LOW;
    end

    // decoded control and result arithmetic
    always_comb begin
        w_start   = (r_state == IDLE) && w_rise;
        w_publish = (r_state == LOW) && w_rise;
        w_timeout = ((r_state == HIGH) && (r_hcnt >= TO) && !w_fall) ||
                    ((r_state == LOW) && (r_lcnt >= TO) && !w_rise);
        w_sum     = {1'b0, r_hcnt} + {1'b0, r_lcnt};
        w_period  = w_sum[CNT_W] ? MAX_CNT : w_sum[CNT_W-1:0];
        w_mcnt    = (!r_first && (w_period == r_period)) ?
                    ((r_mcnt == M_TOP) ? r_mcnt : r_mcnt + MW'(1)) : '0;
    end

    // phase counters, published results and lock/timeout status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt   <= '0;
            r_lcnt   <= '0;
            r_period <= '0;
            r_high   <= '0;
            r_mcnt   <= '0;
            r_first  <= 1'b0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_no_clk <= 1'b0;
        end else begin
            r_valid <= w_publish;
            if (w_start) begin
                r_hcnt   <= CNT_W'(1);
                r_lcnt   <= '0;
                r_no_clk <= 1'b0;
                r_first  <= 1'b1;
            end else if (w_publish) begin
                r_hcnt   <= CNT_W'(1);
                r_lcnt   <= '0;
                r_period <= w_period;
                r_high   <= r_hcnt;
                r_mcnt   <= w_mcnt;
                r_locked <= (w_mcnt == M_TOP);
                r_first  <= 1'b0;
            end else if ((r_state == HIGH) && w_fall) begin
                r_lcnt <= CNT_W'(1);
            end else if (w_timeout) begin
                r_no_clk <= 1'b1;
                r_locked <= 1'b0;
                r_mcnt   <= '0;
            end else if (r_state == HIGH) begin
                r_hcnt <= (r_hcnt == MAX_CNT) ? r_hcnt : r_hcnt + CNT_W'(1);
            end else if (r_state == LOW) begin
                r_lcnt <= (r_lcnt == MAX_CNT) ? r_lcnt : r_lcnt + CNT_W'(1);
            end
        end
    end

`ifdef CLK_RATIO_METER_DUTY_CHECK_EN
    logic [CNT_W-1:0] w_diff;
    logic             r_duty;
    assign w_diff = (r_hcnt > r_lcnt) ? r_hcnt - r_lcnt : r_lcnt - r_hcnt;
    // phases differing by one count are accepted so odd-ratio 50% dividers pass
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_duty <= 1'b0;
        else if (w_publish) r_duty <= (w_diff > CNT_W'(1));
        else if (w_timeout) r_duty <= 1'b0;
    end
    assign duty_err = r_duty;
`else
    assign duty_err = 1'b0;
`endif

    assign period     = r_period;
    assign high_time  = r_high;
    assign meas_valid = r_valid;
    assign locked     = r_locked;
    assign no_clk     = r_no_clk;
endmodule

// File: tb/tb_clk_ratio_meter.sv
// tb_clk_ratio_meter: random-segment stimulus against a cycle-level expectation model
module tb_clk_ratio_meter;
    localparam int LOCK = 4;
`ifdef CLK_RATIO_METER_DUTY_CHECK_EN
    localparam int DUTY_ON = 1;
`else
    localparam int DUTY_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_in = 1'b0;
    logic [15:0] period, high_time;
    logic        meas_valid, locked, no_clk, duty_err;

    int n_checks = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_unexp = 0;
    int have_prev = 0, ph = 0, pl = 0, runlen = 0, last_p = 0, last_h = 0;
    int qp[$], qh[$], ql[$], qd[$];

    always #5 clk = ~clk;

    clk_ratio_meter dut (
        .clk        (clk),
        .rst        (rst),
        .clk_in     (clk_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .no_clk     (no_clk),
        .duty_err   (duty_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        have_prev = 0;
        runlen = 0;
    endtask

    task automatic on_rise();
        int p;
        if (have_prev != 0) begin
            p = ph + pl;
            runlen = (runlen > 0 && p == last_p) ? runlen + 1 : 1;
            last_p = p;
            last_h = ph;
            qp.push_back(p);
            qh.push_back(ph);
            ql.push_back(runlen >= LOCK ? 1 : 0);
`ifdef CLK_RATIO_METER_DUTY_CHECK_EN
            qd.push_back(((ph > pl) ? ph - pl : pl - ph) > 1 ? 1 : 0);
`else
            qd.push_back(0);
`endif
        end
    endtask

    task automatic run(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            on_rise();
            clk_in = 1'b1;
            repeat (h) @(negedge clk);
            clk_in = 1'b0;
            repeat (l) @(negedge clk);
            ph = h;
            pl = l;
            have_prev = 1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, period, 0);
        check({tag, "_high"}, high_time, 0);
        check({tag, "_valid"}, meas_valid, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_no_clk"}, no_clk, 0);
        check({tag, "_duty"}, duty_err, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && meas_valid) begin
            n_valid++;
            if (qp.size() == 0) begin
                n_unexp++;
            end else begin
                check("period", period, qp.pop_front());
                check("high_time", high_time, qh.pop_front());
                check("locked", locked, ql.pop_front());
                check("duty_err", duty_err, qd.pop_front());
                check("no_clk_at_valid", no_clk, 0);
            end
        end
    end

    initial begin
        int nv, h, l;
        #2 rst = 1'b1;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        run(6, 6, 8);
        check("steady12_locked", locked, 1);
        check("steady12_period", period, 12);
        check("steady12_high", high_time, 6);
        run(7, 7, 6);
        check("steady14_locked", locked, 1);
        check("steady14_period", period, 14);
        run(2, 2, 5);
        check("min_phase_period", period, 4);

        for (int s = 0; s < 12; s++) begin
            h = $urandom_range(2, 20);
            l = $urandom_range(2, 20);
            run(h, l, $urandom_range(1, 5));
        end

        run(4, 8, 3);
        check("duty_4_8_period", period, 12);
        check("duty_4_8_err", duty_err, DUTY_ON);
        run(6, 7, 3);
        check("duty_6_7_period", period, 13);
        check("duty_6_7_err", duty_err, 0);

        on_rise();
        clk_in = 1'b1;
        repeat (990) @(negedge clk);
        check("stuck_early_no_clk", no_clk, 0);
        repeat (20) @(negedge clk);
        check("stuck_no_clk", no_clk, 1);
        check("stuck_locked", locked, 0);
        check("stuck_period_hold", period, last_p);
        check("stuck_high_hold", high_time, last_h);
        check("stuck_duty", duty_err, 0);
        model_clear();
        clk_in = 1'b0;
        repeat (20) @(negedge clk);
        nv = n_valid;
        run(5, 5, 1);
        check("restart_no_clk_clear", no_clk, 0);
        check("restart_no_first_valid", n_valid, nv);
        run(6, 6, 6);
        check("relock", locked, 1);

        on_rise();
        clk_in = 1'b1;
        repeat (6) @(negedge clk);
        clk_in = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midlow_reset");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        nv = n_valid;
        run(6, 6, 1);
        check("post_reset_no_first_valid", n_valid, nv);
        run(6, 6, 3);
        check("post_reset_period", period, 12);
        repeat (10) @(negedge clk);

        check("pending_results", qp.size(), 0);
        check("unexpected_valids", n_unexp, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
